video_downscaler_2x2_mc: RTL and testbench

VIDEO_DOWNSCALER_2X2_MC -- requirements
Module: video_downscaler_2x2_mc

---
 rtl/video_downscaler_2x2_mc.sv | 160 ++++++++++++++++
 tb/tb_video_downscaler_2x2_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_downscaler_2x2_mc.sv
// Video 2:1 horizontal / 2x2 box downscaler with framelock, a half-line pair-sum
// buffer and a small output FIFO that is written on the accepting edge.
module video_downscaler_2x2_mc_lane #(
  parameter int D_WIDTH = 8,
  parameter int ROUND   = 0
) (
  input  logic [D_WIDTH-1:0] a,
  input  logic [D_WIDTH-1:0] b,
  input  logic [D_WIDTH:0]   lb,
  output logic [D_WIDTH:0]   hsum,
  output logic [D_WIDTH-1:0] havg,
  output logic [D_WIDTH-1:0] vavg
);
  logic [D_WIDTH+1:0] hr;
  logic [D_WIDTH+2:0] vs;

  always_comb begin
    hsum = {1'b0, a} + {1'b0, b};
    hr   = {1'b0, hsum} + (D_WIDTH+2)'(ROUND);
    vs   = {2'b0, hsum} + {2'b0, lb} + (D_WIDTH+3)'(2*ROUND);
    havg = D_WIDTH'(hr >> 1);
    vavg = D_WIDTH'(vs >> 2);
  end
endmodule

module video_downscaler_2x2_mc #(
  parameter int D_WIDTH   = 8,
  parameter int CHANNELS  = 3,
  parameter int MAX_WIDTH = 1920,
  parameter int OUT_DEPTH = 4,
  parameter int ROUND     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  mode,
  input  logic [CHANNELS*D_WIDTH-1:0] up_data,
  input  logic                        up_tlast,
  input  logic                        up_tuser,
  input  logic                        up_valid,
  output logic                        up_ready,
  output logic [CHANNELS*D_WIDTH-1:0] down_data,
  output logic                        down_tlast,
  output logic                        down_tuser,
  output logic                        down_valid,
  input  logic                        down_ready,
  output logic                        err_width
);
  localparam int PW = CHANNELS*D_WIDTH;
  localparam int SW = CHANNELS*(D_WIDTH+1);
  localparam int LB_DEPTH = (MAX_WIDTH+1)/2;
  localparam int KW = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam int CW = $clog2(MAX_WIDTH+1);
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int NW = $clog2(OUT_DEPTH+1);
  localparam int FW = PW + 2;

  logic          framelock, line_odd, have_half, first_out, err_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] px_cnt;
  logic [PW-1:0] half_q;
  logic [SW-1:0] lb [LB_DEPTH];
  logic [FW-1:0] mem [OUT_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;

  logic          acc, pop, push, live, pair_done;
  logic          half_e, odd_e, is_byp, is_h, is_2x2, in_range, last_px, first_e;
  logic [1:0]    mode_e;
  logic [CW-1:0] idx;
  logic [KW-1:0] k;
  logic [PW-1:0] pair_a, havg, vavg;
  logic [SW-1:0] hsum, lb_rd;
  logic [FW-1:0] push_data;

  // A tuser beat restarts everything, so its own processing uses fresh state.
  always_comb begin
    acc      = up_valid & up_ready;
    pop      = down_valid & down_ready;
    mode_e   = up_tuser ? mode : mode_q;
    idx      = up_tuser ? '0 : px_cnt;
    half_e   = up_tuser ? 1'b0 : have_half;
    odd_e    = up_tuser ? 1'b0 : line_odd;
    first_e  = up_tuser | first_out;
    live     = acc & (framelock | up_tuser);
    is_byp   = (mode_e == 2'b00);
    is_h     = (mode_e == 2'b01);
    is_2x2   = mode_e[1];
    in_range = !is_2x2 || (idx < CW'(MAX_WIDTH));
    // Last kept pixel of an over-long line closes the pair and the output line.
    last_px  = up_tlast | (is_2x2 & (idx == CW'(MAX_WIDTH-1)));
    pair_done = live & !is_byp & in_range & (half_e | last_px);
    pair_a   = half_e ? half_q : up_data;
    k        = KW'(idx >> 1);
    lb_rd    = lb[k];
    push     = live & (is_byp | (pair_done & (is_h | odd_e)));
    push_data = is_byp ? {up_tuser, up_tlast, up_data}
                       : {first_e, last_px, (is_h ? havg : vavg)};
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    video_downscaler_2x2_mc_lane #(.D_WIDTH(D_WIDTH), .ROUND(ROUND)) u_lane (
      .a    (pair_a[c*D_WIDTH +: D_WIDTH]),
      .b    (up_data[c*D_WIDTH +: D_WIDTH]),
      .lb   (lb_rd[c*(D_WIDTH+1) +: D_WIDTH+1]),
      .hsum (hsum[c*(D_WIDTH+1) +: D_WIDTH+1]),
      .havg (havg[c*D_WIDTH +: D_WIDTH]),
      .vavg (vavg[c*D_WIDTH +: D_WIDTH])
    );
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OUT_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      framelock <= 1'b0;
      mode_q    <= '0;
      px_cnt    <= '0;
      line_odd  <= 1'b0;
      have_half <= 1'b0;
      half_q    <= '0;
      first_out <= 1'b0;
      err_q     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (live) begin
        framelock <= 1'b1;
        half_q    <= up_data;
        first_out <= push ? 1'b0 : first_e;
        if (up_tuser) mode_q <= mode;
        if (is_2x2 && !in_range) err_q <= 1'b1;
        if (up_tlast) begin
          px_cnt    <= '0;
          have_half <= 1'b0;
          line_odd  <= ~odd_e;
        end else begin
          px_cnt    <= (idx == CW'(MAX_WIDTH)) ? idx : idx + 1'b1;
          have_half <= !is_byp & in_range & !half_e & !last_px;
          line_odd  <= odd_e;
        end
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + NW'(push) - NW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (pair_done && is_2x2 && !odd_e) lb[k] <= hsum;
    if (push) mem[wr_ptr] <= push_data;
  end

  assign up_ready   = rst & (count < NW'(OUT_DEPTH));
  assign down_valid = rst & (count != '0);
  assign {down_tuser, down_tlast, down_data} = down_valid ? mem[rd_ptr] : '0;
  assign err_width  = err_q;
endmodule

// File: tb/tb_video_downscaler_2x2_mc.sv
// Two downscalers (truncating and rounding) fed the same random/directed video
// and compared against a line-level arithmetic model.
module tb_video_downscaler_2x2_mc;
  localparam int D = 8, C = 4, MW = 8, DEP = 4, PW = D*C;
  typedef logic [PW+1:0] beat_t;

  logic clk = 0, rst = 0;
  logic [1:0] mode = 0;
  logic [PW-1:0] up_data = 0;
  logic up_tlast = 0, up_tuser = 0, up_valid = 0;
  logic up_ready0, up_ready1, down_valid0, down_valid1, down_tlast0, down_tlast1;
  logic down_tuser0, down_tuser1, err0, err1, down_ready;
  logic [PW-1:0] down_data0, down_data1;

  always #5 clk = ~clk;

  video_downscaler_2x2_mc #(.D_WIDTH(D), .CHANNELS(C), .MAX_WIDTH(MW), .OUT_DEPTH(DEP), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .up_data(up_data), .up_tlast(up_tlast), .up_tuser(up_tuser),
    .up_valid(up_valid), .up_ready(up_ready0), .down_data(down_data0), .down_tlast(down_tlast0),
    .down_tuser(down_tuser0), .down_valid(down_valid0), .down_ready(down_ready), .err_width(err0));
  video_downscaler_2x2_mc #(.D_WIDTH(D), .CHANNELS(C), .MAX_WIDTH(MW), .OUT_DEPTH(DEP), .ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .up_data(up_data), .up_tlast(up_tlast), .up_tuser(up_tuser),
    .up_valid(up_valid), .up_ready(up_ready1), .down_data(down_data1), .down_tlast(down_tlast1),
    .down_tuser(down_tuser1), .down_valid(down_valid1), .down_ready(down_ready), .err_width(err1));

  int n_chk = 0, n_fail = 0, n_acc = 0, base0 = 0, base1 = 0, hold_err = 0, sync_err = 0;
  beat_t exp0[$], exp1[$], act0[$], act1[$];
  bit rnd_ready = 0, rnd_bit = 1, ready_force = 1;
  assign down_ready = rnd_ready ? rnd_bit : ready_force;
  always @(posedge clk) begin #1; rnd_bit = ($urandom_range(0, 3) != 0); end

  // output monitor, sampled on the falling edge
  beat_t held; bit hold = 0;
  always @(negedge clk) begin
    if (up_ready0 !== up_ready1 || down_valid0 !== down_valid1) sync_err++;
    if (hold && down_valid0 && {down_tuser0, down_tlast0, down_data0} !== held) hold_err++;
    hold = down_valid0 && !down_ready;
    held = {down_tuser0, down_tlast0, down_data0};
    if (down_valid0 && down_ready) act0.push_back({down_tuser0, down_tlast0, down_data0});
    if (down_valid1 && down_ready) act1.push_back({down_tuser1, down_tlast1, down_data1});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- reference model: whole lines reduced with plain arithmetic ----
  bit m_lock = 0, m_first = 0, m_err = 0;
  int m_mode = 0, m_line = 0;
  int prev [4][16];
  logic [PW-1:0] cur[$];

  function automatic logic [PW-1:0] rep(input int v);
    logic [7:0] b = 8'(v);
    return {b, b, b, b};
  endfunction
  function automatic logic [PW-1:0] avg2(input logic [PW-1:0] a, input logic [PW-1:0] b, input int r);
    logic [PW-1:0] o;
    for (int ch = 0; ch < C; ch++)
      o[ch*8 +: 8] = 8'((int'(a[ch*8 +: 8]) + int'(b[ch*8 +: 8]) + r) / 2);
    return o;
  endfunction
  function automatic logic [PW-1:0] avg4(input logic [PW-1:0] a, input logic [PW-1:0] b, input int j, input int r);
    logic [PW-1:0] o;
    for (int ch = 0; ch < C; ch++)
      o[ch*8 +: 8] = 8'((prev[ch][j] + int'(a[ch*8 +: 8]) + int'(b[ch*8 +: 8]) + 2*r) / 4);
    return o;
  endfunction

  task automatic put(input logic [PW-1:0] d0, input logic [PW-1:0] d1, input bit last);
    exp0.push_back({m_first, last, d0});
    exp1.push_back({m_first, last, d1});
    m_first = 0;
  endtask

  task automatic flush(input bit ended);
    int n, m, np;
    bit closed;
    logic [PW-1:0] a, b;
    n = cur.size();
    if (m_mode == 1) begin m = n; closed = ended; end
    else begin m = (n < MW) ? n : MW; closed = ended || n >= MW; end
    np = closed ? (m + 1) / 2 : m / 2;
    for (int j = 0; j < np; j++) begin
      a = cur[2*j];
      b = (2*j + 1 < m) ? cur[2*j + 1] : a;
      if (m_mode == 1) put(avg2(a, b, 0), avg2(a, b, 1), closed && j == np - 1);
      else if (m_line % 2 == 0) begin
        for (int ch = 0; ch < C; ch++) prev[ch][j] = int'(a[ch*8 +: 8]) + int'(b[ch*8 +: 8]);
      end else put(avg4(a, b, j, 0), avg4(a, b, j, 1), closed && j == np - 1);
    end
    cur.delete();
  endtask

  task automatic model_beat(input logic [PW-1:0] d, input bit last, input bit user, input logic [1:0] md);
    if (user) begin
      if (m_lock && m_mode != 0) flush(0);
      m_lock = 1; m_mode = md[1] ? 2 : int'(md[0]); m_line = 0; m_first = 1;
      cur.delete();
    end
    if (!m_lock) return;
    if (m_mode == 0) begin
      exp0.push_back({user, last, d}); exp1.push_back({user, last, d});
      m_first = 0;
      return;
    end
    cur.push_back(d);
    if (m_mode == 2 && cur.size() > MW) m_err = 1;
    if (last) begin flush(1); m_line++; end
  endtask

  task automatic model_reset();
    m_lock = 0; m_first = 0; m_err = 0;
    cur.delete();
  endtask

  // ---- stimulus ----
  task automatic send(input logic [PW-1:0] d, input bit last, input bit user, input logic [1:0] md, input int gap);
    int t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    up_data = d; up_tlast = last; up_tuser = user; mode = md; up_valid = 1;
    @(negedge clk);
    while (!up_ready0 && t < 300) begin @(negedge clk); t++; end
    if (up_ready0) begin model_beat(d, last, user, md); n_acc++; end
    else chk("send_timeout", up_ready0, 1);
    @(posedge clk); #1;
    up_valid = 0; up_tlast = 0; up_tuser = 0;
  endtask

  task automatic line(input int v[$], input bit first, input logic [1:0] md);
    for (int i = 0; i < v.size(); i++) send(rep(v[i]), i == v.size() - 1, first && i == 0, md, 0);
  endtask

  task automatic rand_line(input int w, input bit first, input logic [1:0] md, input bit close, input int gmax);
    for (int i = 0; i < w; i++)
      send(PW'($urandom()), close && i == w - 1, first && i == 0,
           (first && i == 0) ? md : 2'($urandom_range(0, 3)), $urandom_range(0, gmax));
  endtask

  task automatic drain(input string tag);
    int t = 0;
    rnd_ready = 0; ready_force = 1;
    while ((act0.size() - base0 < exp0.size() || act1.size() - base1 < exp1.size()) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    repeat (4) begin @(posedge clk); #1; end
    chk({tag, "_cnt0"}, act0.size() - base0, exp0.size());
    chk({tag, "_cnt1"}, act1.size() - base1, exp1.size());
    for (int i = 0; i < exp0.size() && base0 + i < act0.size(); i++) chk({tag, "_out0"}, act0[base0 + i], exp0[i]);
    for (int i = 0; i < exp1.size() && base1 + i < act1.size(); i++) chk({tag, "_out1"}, act1[base1 + i], exp1[i]);
    chk({tag, "_err0"}, err0, m_err);
    chk({tag, "_err1"}, err1, m_err);
    chk({tag, "_hold"}, hold_err, 0);
    chk({tag, "_sync"}, sync_err, 0);
    base0 = act0.size(); base1 = act1.size();
    exp0.delete(); exp1.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_up_ready"}, up_ready0, 0);
    chk({tag, "_down_valid"}, down_valid0, 0);
    chk({tag, "_down_data"}, down_data0, 0);
    chk({tag, "_down_tlast"}, down_tlast0, 0);
    chk({tag, "_down_tuser"}, down_tuser0, 0);
    chk({tag, "_err"}, err0, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end

  initial begin
    int q[$];
    int b0, b1, w, nl;
    bit abort;
    logic [1:0] md;

    repeat (3) @(posedge clk); #1;
    chk_zero("reset");
    rst = 1;
    @(posedge clk); #1;
    chk("reset_release_ready", up_ready0, 1);

    // beats before any tuser are dropped
    for (int i = 0; i < 3; i++) send(PW'($urandom()), i == 2, 0, 2'b00, 0);
    drain("pretuser");

    // 2x2 averaging
    q = '{10, 20, 30, 40}; line(q, 1, 2'b10);
    q = '{50, 60, 70, 80}; line(q, 0, 2'b10);
    b0 = base0; drain("x2");
    if (act0.size() >= b0 + 2) begin
      chk("x2_first", act0[b0], {2'b10, rep(35)});
      chk("x2_second", act0[b0 + 1], {2'b01, rep(55)});
    end

    // odd width pads with the last pixel
    q = '{4, 8, 12}; line(q, 1, 2'b11);
    q = '{4, 8, 20}; line(q, 0, 2'b11);
    b0 = base0; drain("odd");
    if (act0.size() >= b0 + 2) begin
      chk("odd_first", act0[b0], {2'b10, rep(6)});
      chk("odd_second", act0[b0 + 1], {2'b01, rep(16)});
    end

    // horizontal rounding and saturation-free full scale
    q = '{1, 2}; line(q, 1, 2'b01);
    q = '{255, 255}; line(q, 0, 2'b01);
    b0 = base0; b1 = base1; drain("hround");
    if (act0.size() >= b0 + 2 && act1.size() >= b1 + 1) begin
      chk("hround_trunc", act0[b0], {2'b11, rep(1)});
      chk("hround_round", act1[b1], {2'b11, rep(2)});
      chk("hround_255", act0[b0 + 1], {2'b01, rep(255)});
    end

    // bypass backpressure and output latency
    ready_force = 0;
    chk("lat_idle", down_valid0, 0);
    n_acc = 0;
    send(rep(1), 0, 1, 2'b00, 0);
    chk("lat_one_cycle", down_valid0, 1);
    fork
      for (int i = 2; i <= 6; i++) send(rep(i), i == 6, 0, 2'b00, 0);
      begin
        repeat (20) @(posedge clk); #1;
        chk("bp_accepted", n_acc, DEP);
        chk("bp_up_ready", up_ready0, 0);
        ready_force = 1;
      end
    join
    b0 = base0; drain("bp");
    if (act0.size() >= b0 + 6) chk("bp_last", act0[b0 + 5], {2'b01, rep(6)});

    // over-long lines in 2x2
    rand_line(10, 1, 2'b10, 1, 0); rand_line(10, 0, 2'b10, 1, 0);
    b0 = base0; drain("ovf");
    chk("ovf_count", base0 - b0, 4);
    if (base0 - b0 == 4) chk("ovf_tlast", act0[b0 + 3][PW], 1);
    rand_line(4, 1, 2'b10, 1, 0); rand_line(4, 0, 2'b10, 1, 0);
    drain("ovf_next");
    chk("err_sticky", err0, 1);
    rand_line(10, 1, 2'b10, 1, 0); rand_line(5, 0, 2'b10, 0, 0);
    rand_line(6, 1, 2'b10, 1, 0); rand_line(6, 0, 2'b10, 1, 0);
    drain("restart");

    // reset in the middle of a frame
    rand_line(3, 1, 2'b10, 0, 0);
    rst = 0;
    repeat (3) @(posedge clk); #1;
    chk_zero("midreset");
    model_reset();
    rst = 1;
    @(posedge clk); #1;
    chk("midreset_release_ready", up_ready0, 1);
    for (int i = 0; i < 3; i++) send(PW'($urandom()), 0, 0, 2'b01, 0);
    drain("midreset_pretuser");

    // random frames, random stalls, mid-frame mode noise and aborted frames
    for (int f = 0; f < 40; f++) begin
      md = 2'($urandom_range(0, 3));
      w = $urandom_range(1, 10);
      nl = $urandom_range(1, 4);
      abort = (f != 39) && ($urandom_range(0, 7) == 0);
      rnd_ready = 1;
      for (int l = 0; l < nl; l++) rand_line(w, l == 0, md, 1, 2);
      if (abort) rand_line((w + 1) / 2, 0, md, 0, 2);
      else drain("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
